game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Game-flow sequencer that drives the text-overlay screen selects (`is_menu`, `is_playing`, `is_level_done`, `is_game_over`, `is_game_win`). It tracks level and lives, and qualifies the fire button so a held press never skips a screen. It sits between the input/gameplay logic and the overlay renderer, which consumes its one-hot screen outputs directly.

## Interface
- `NUM_LEVELS`, 4: number of levels; clearing level `NUM_LEVELS-1` wins the game.
- `START_LIVES`, 3: lives loaded at game start.
- `HOLDOFF_FRAMES`, 30: frames a new screen ignores the fire button.
- `ATTRACT_FRAMES`, 600: idle frames before an end screen returns to menu (used only with `GAME_FLOW_ATTRACT_EN`).
- `clk_i` in 1: system/pixel clock; the only clock.
- `reset_i` in 1: synchronous, active-high reset.
- `frame_tick_i` in 1: one-cycle pulse per video frame.
- `shoot_i` in 1: fire button level, already synchronized to `clk_i`.
- `player_hit_i` in 1: one-cycle pulse when the player loses a life.
- `level_cleared_i` in 1: one-cycle pulse when all enemies of the level are gone.
- `is_menu_o`, `is_playing_o`, `is_level_done_o`, `is_game_over_o`, `is_game_win_o` out 1 each: registered one-hot screen state.
- `level_o` out `max(1,$clog2(NUM_LEVELS))`: current level index, 0-based.
- `lives_o` out `$clog2(START_LIVES+1)`: remaining lives.
- `level_start_o` out 1: one-cycle pulse; playfield must (re)initialize the level.
- `game_reset_o` out 1: one-cycle pulse; score and playfield full reset.

## Operation
- States: MENU, PLAYING, LEVEL_DONE, GAME_OVER, GAME_WIN. Exactly one `is_*_o` is high at all times.
- Press detection:
  - `press` = `shoot_i` AND NOT `shoot_q` AND (`holdoff` == 0).
  - `shoot_q` is the previous-cycle `shoot_i`.
- Holdoff counter:
  - Reloads to `HOLDOFF_FRAMES` on every state change and on reset.
  - Decrements on `frame_tick_i` while nonzero.
  - `press` uses the pre-decrement value.
- Transitions:
  - MENU + press -> PLAYING. Set `level`=0 and `lives`=`START_LIVES`. Pulse `game_reset_o` and `level_start_o`.
  - PLAYING + `player_hit_i`:
    - If `lives` == 1: `lives`=0, go to GAME_OVER.
    - Otherwise: `lives`-1, stay in PLAYING.
  - PLAYING + `level_cleared_i`:
    - If `level` == `NUM_LEVELS-1`: go to GAME_WIN.
    - Otherwise: go to LEVEL_DONE.
  - Simultaneous hit and clear: the hit is evaluated first. A fatal hit goes to GAME_OVER and the clear is dropped. A non-fatal hit decrements `lives`, and the clear still applies in the same cycle.
  - LEVEL_DONE + press -> PLAYING with `level`+1. Pulse `level_start_o` only.
  - GAME_OVER or GAME_WIN + press -> MENU. `level` and `lives` are retained for display until the next game start.
- `player_hit_i` and `level_cleared_i` are ignored outside PLAYING.
- `level` never exceeds `NUM_LEVELS-1`. `lives` never underflows.

## Timing
- All outputs are registered. The state and counters update on the `clk_i` edge that samples the event; outputs change 1 cycle after the input pulse or rising edge of `shoot_i`.
- `level_start_o` and `game_reset_o` are high for exactly the first cycle in which the new `is_playing_o` is high.
- Reset values:
  - `is_menu_o`=1; all other `is_*_o`=0.
  - `level_o`=0, `lives_o`=0.
  - Pulses 0.
  - `holdoff`=`HOLDOFF_FRAMES`.
  - `shoot_q`=1, so a button held through reset produces no press.
- Reset asserted mid-game returns to MENU on the next edge, regardless of other inputs.
- `HOLDOFF_FRAMES`=0 means press is accepted on the first edge after entry.
- The button must be released and re-pressed after holdoff expires. A level held since before expiry is not a press.

## Configuration
- `GAME_FLOW_ATTRACT_EN` defined:
  - An idle counter clears on entry to GAME_OVER/GAME_WIN and increments on `frame_tick_i`.
  - When it reaches `ATTRACT_FRAMES` with no press, the state goes to MENU (holdoff reloads).
  - A press in the same cycle is equivalent, since both targets are MENU.
- Undefined: no idle counter; end screens persist until a press.

## Test plan
- Reset with `shoot_i`=1 held, 40 frame ticks -> stays MENU. Release, wait 30 ticks, then a rising edge -> next cycle `is_playing_o`=1, `level_o`=0, `lives_o`=3, `level_start_o` and `game_reset_o` high for 1 cycle.
- In PLAYING, 3 `player_hit_i` pulses -> `lives_o` 2, 1, then GAME_OVER with `lives_o`=0. A press after holdoff -> MENU.
- Clear levels 0-2 with presses between -> LEVEL_DONE each time and `level_o` increments. Clear level 3 -> GAME_WIN.
- `lives`=1 with `player_hit_i` and `level_cleared_i` in the same cycle -> GAME_OVER, `level_o` unchanged. With `lives`=2 -> LEVEL_DONE, `lives_o`=1.
- Press edge at LEVEL_DONE entry+5 ticks -> ignored. Edge after 30 ticks -> PLAYING. `reset_i` pulse during PLAYING -> MENU next cycle, `level_o`=0.
- With `GAME_FLOW_ATTRACT_EN`: GAME_OVER idle for 600 ticks -> MENU on the 600th tick. Without the macro: still GAME_OVER after 1000 ticks.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - game-flow sequencer driving one-hot overlay screen selects
//
// Purpose: tracks the game screen (menu, playing, level done, game over, game win),
// the current level and remaining lives, and qualifies the fire button so that a held
// press never skips a screen.
// Optional feature: define GAME_FLOW_ATTRACT_EN to return from an end screen to the
// menu after ATTRACT_FRAMES idle frames.
//
// Ports:
//   clk_i             system/pixel clock
//   reset_i           synchronous active-high reset
//   frame_tick_i      one-cycle pulse per video frame
//   shoot_i           fire button level (already synchronized)
//   player_hit_i      one-cycle pulse, player loses a life
//   level_cleared_i   one-cycle pulse, all enemies of the level gone
//   is_*_o            registered one-hot screen selects
//   level_o           current level index, 0-based
//   lives_o           remaining lives
//   level_start_o     one-cycle pulse, playfield (re)initializes the level
//   game_reset_o      one-cycle pulse, score and playfield full reset
module game_flow_ctrl #(
  parameter int NUM_LEVELS     = 4,
  parameter int START_LIVES    = 3,
  parameter int HOLDOFF_FRAMES = 30,
  parameter int ATTRACT_FRAMES = 600,
  localparam int LW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int VW = $clog2(START_LIVES + 1)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          frame_tick_i,
  input  logic          shoot_i,
  input  logic          player_hit_i,
  input  logic          level_cleared_i,
  output logic          is_menu_o,
  output logic          is_playing_o,
  output logic          is_level_done_o,
  output logic          is_game_over_o,
  output logic          is_game_win_o,
  output logic [LW-1:0] level_o,
  output logic [VW-1:0] lives_o,
  output logic          level_start_o,
  output logic          game_reset_o
);

  localparam int HW = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;

  // One-hot encoding so each screen select is a flop output with no decode logic.
  typedef enum logic [4:0] {
    MENU       = 5'b00001,
    PLAYING    = 5'b00010,
    LEVEL_DONE = 5'b00100,
    GAME_OVER  = 5'b01000,
    GAME_WIN   = 5'b10000
  } state_t;

  state_t        state, next_state;
  logic [LW-1:0] level, next_level;
  logic [VW-1:0] lives, next_lives;
  logic [HW-1:0] holdoff;
  logic          shoot_q;
  logic          level_start, next_level_start;
  logic          game_reset, next_game_reset;
  logic          press;
  logic          attract_expire;

  // Rising edge only, and only once the screen's holdoff has run out; the pre-decrement
  // holdoff value is used so the press lands strictly after the last ignored frame.
  assign press = shoot_i && !shoot_q && (holdoff == '0);

`ifdef GAME_FLOW_ATTRACT_EN
  localparam int IW = (ATTRACT_FRAMES > 0) ? $clog2(ATTRACT_FRAMES + 1) : 1;
  logic [IW-1:0] idle;

  always_ff @(posedge clk_i) begin
    if (reset_i || (next_state != state)) begin
      idle <= '0;
    end else if (frame_tick_i && (idle != IW'(ATTRACT_FRAMES))) begin
      idle <= idle + IW'(1);
    end
  end

  // Fires on the frame tick that brings the idle count to ATTRACT_FRAMES.
  assign attract_expire = frame_tick_i && (idle == IW'(ATTRACT_FRAMES - 1));
`else
  assign attract_expire = 1'b0;
`endif

  always_comb begin
    next_state       = state;
    next_level       = level;
    next_lives       = lives;
    next_level_start = 1'b0;
    next_game_reset  = 1'b0;
    unique case (state)
      MENU: begin
        if (press) begin
          next_state       = PLAYING;
          next_level       = '0;
          next_lives       = VW'(START_LIVES);
          next_level_start = 1'b1;
          next_game_reset  = 1'b1;
        end
      end
      PLAYING: begin
        // Hit is resolved first; a fatal hit swallows a simultaneous clear.
        if (player_hit_i && (lives <= VW'(1))) begin
          next_lives = '0;
          next_state = GAME_OVER;
        end else begin
          if (player_hit_i) begin
            next_lives = lives - VW'(1);
          end
          if (level_cleared_i) begin
            next_state = (level == LW'(NUM_LEVELS - 1)) ? GAME_WIN : LEVEL_DONE;
          end
        end
      end
      LEVEL_DONE: begin
        if (press) begin
          next_state       = PLAYING;
          next_level       = (level == LW'(NUM_LEVELS - 1)) ? level : level + LW'(1);
          next_level_start = 1'b1;
        end
      end
      GAME_OVER, GAME_WIN: begin
        // Level and lives are kept for display until the next game start.
        if (press || attract_expire) begin
          next_state = MENU;
        end
      end
      default: next_state = MENU;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= MENU;
      level       <= '0;
      lives       <= '0;
      holdoff     <= HW'(HOLDOFF_FRAMES);
      shoot_q     <= 1'b1;  // a button held through reset must not count as a press
      level_start <= 1'b0;
      game_reset  <= 1'b0;
    end else begin
      state       <= next_state;
      level       <= next_level;
      lives       <= next_lives;
      shoot_q     <= shoot_i;
      level_start <= next_level_start;
      game_reset  <= next_game_reset;
      if (next_state != state) begin
        holdoff <= HW'(HOLDOFF_FRAMES);
      end else if (frame_tick_i && (holdoff != '0)) begin
        holdoff <= holdoff - HW'(1);
      end
    end
  end

  assign is_menu_o       = state[0];
  assign is_playing_o    = state[1];
  assign is_level_done_o = state[2];
  assign is_game_over_o  = state[3];
  assign is_game_win_o   = state[4];
  assign level_o         = level;
  assign lives_o         = lives;
  assign level_start_o   = level_start;
  assign game_reset_o    = game_reset;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - directed self-checking bench for game_flow_ctrl
module tb_game_flow_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       shoot = 1'b0;
  logic       player_hit = 1'b0;
  logic       level_cleared = 1'b0;
  logic       is_menu, is_playing, is_level_done, is_game_over, is_game_win;
  logic [1:0] level;
  logic [1:0] lives;
  logic       level_start, game_reset;

  int checks = 0;
  int errors = 0;

  game_flow_ctrl dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .frame_tick_i    (frame_tick),
    .shoot_i         (shoot),
    .player_hit_i    (player_hit),
    .level_cleared_i (level_cleared),
    .is_menu_o       (is_menu),
    .is_playing_o    (is_playing),
    .is_level_done_o (is_level_done),
    .is_game_over_o  (is_game_over),
    .is_game_win_o   (is_game_win),
    .level_o         (level),
    .lives_o         (lives),
    .level_start_o   (level_start),
    .game_reset_o    (game_reset)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Screen as a 5-bit one-hot vector {win, over, done, playing, menu}.
  function automatic logic [4:0] screen();
    return {is_game_win, is_game_over, is_level_done, is_playing, is_menu};
  endfunction

  localparam logic [4:0] S_MENU = 5'b00001;
  localparam logic [4:0] S_PLAY = 5'b00010;
  localparam logic [4:0] S_DONE = 5'b00100;
  localparam logic [4:0] S_OVER = 5'b01000;
  localparam logic [4:0] S_WIN  = 5'b10000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    frame_tick = 1'b1;
    repeat (n) step();
    frame_tick = 1'b0;
  endtask

  // Rising edge of the button; outputs reflect it when the task returns.
  task automatic press();
    shoot = 1'b1;
    step();
  endtask

  task automatic release_btn();
    shoot = 1'b0;
    step();
  endtask

  task automatic hit();
    player_hit = 1'b1;
    step();
    player_hit = 1'b0;
  endtask

  task automatic clear();
    level_cleared = 1'b1;
    step();
    level_cleared = 1'b0;
  endtask

  task automatic hit_and_clear();
    player_hit = 1'b1;
    level_cleared = 1'b1;
    step();
    player_hit = 1'b0;
    level_cleared = 1'b0;
  endtask

  // From MENU after holdoff reload: start a game and check the start pulses.
  task automatic start_game(input string tag);
    frames(30);
    press();
    check({tag, "_screen"}, screen(), S_PLAY);
    check({tag, "_level"}, level, 0);
    check({tag, "_lives"}, lives, 3);
    check({tag, "_lstart"}, level_start, 1);
    check({tag, "_greset"}, game_reset, 1);
    release_btn();
    check({tag, "_lstart_drop"}, level_start, 0);
    check({tag, "_greset_drop"}, game_reset, 0);
  endtask

  initial begin
    // Reset with the button held.
    shoot = 1'b1;
    step();
    step();
    check("rst_screen", screen(), S_MENU);
    check("rst_level", level, 0);
    check("rst_lives", lives, 0);
    check("rst_lstart", level_start, 0);
    check("rst_greset", game_reset, 0);
    reset = 1'b0;
    frames(40);
    check("held_no_press", screen(), S_MENU);
    release_btn();
    start_game("start1");

    // Three hits to game over, then a press back to menu.
    hit();
    check("hit1_lives", lives, 2);
    check("hit1_screen", screen(), S_PLAY);
    hit();
    check("hit2_lives", lives, 1);
    hit();
    check("hit3_screen", screen(), S_OVER);
    check("hit3_lives", lives, 0);
    hit();
    check("hit_ignored_over", lives, 0);
    frames(30);
    press();
    check("over_to_menu", screen(), S_MENU);
    check("menu_keep_lives", lives, 0);
    release_btn();

    // Level progression, with an early press ignored at level 0.
    start_game("start2");
    for (int l = 0; l < 3; l++) begin
      clear();
      check($sformatf("clr%0d_screen", l), screen(), S_DONE);
      check($sformatf("clr%0d_level", l), level, l);
      if (l == 0) begin
        frames(5);
        press();
        check("early_press_ignored", screen(), S_DONE);
        release_btn();
        frames(25);
      end else begin
        frames(30);
      end
      press();
      check($sformatf("next%0d_screen", l), screen(), S_PLAY);
      check($sformatf("next%0d_level", l), level, l + 1);
      check($sformatf("next%0d_lstart", l), level_start, 1);
      check($sformatf("next%0d_greset", l), game_reset, 0);
      release_btn();
    end
    clear();
    check("win_screen", screen(), S_WIN);
    check("win_level", level, 3);
    check("win_lives", lives, 3);
    frames(30);
    press();
    check("win_to_menu", screen(), S_MENU);
    release_btn();

    // Simultaneous hit and clear.
    start_game("start3");
    hit();
    hit_and_clear();
    check("hc2_screen", screen(), S_DONE);
    check("hc2_lives", lives, 1);
    check("hc2_level", level, 0);
    frames(30);
    press();
    release_btn();
    check("hc_next_level", level, 1);
    hit_and_clear();
    check("hc1_screen", screen(), S_OVER);
    check("hc1_lives", lives, 0);
    check("hc1_level", level, 1);
    frames(30);
    press();
    release_btn();

    // Reset in the middle of a game.
    start_game("start4");
    clear();
    frames(30);
    press();
    release_btn();
    check("pre_rst_level", level, 1);
    reset = 1'b1;
    player_hit = 1'b1;
    step();
    reset = 1'b0;
    player_hit = 1'b0;
    check("midrst_screen", screen(), S_MENU);
    check("midrst_level", level, 0);
    check("midrst_lives", lives, 0);

    // End-screen idle behaviour.
    start_game("start5");
    hit();
    hit();
    hit();
    check("idle_over_entry", screen(), S_OVER);
`ifdef GAME_FLOW_ATTRACT_EN
    frames(599);
    check("attract_599", screen(), S_OVER);
    frames(1);
    check("attract_600", screen(), S_MENU);
`else
    frames(1000);
    check("no_attract_1000", screen(), S_OVER);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
